// File: rtl/fifo_pkg.sv
// Shared read-side FIFO definitions: word width default, prefetch depth,
// memory read latency and the level type used by the read-pointer block.
package fifo_pkg;

    localparam int FIFO_DATA_WIDTH = 8;
    localparam int PF_DEPTH        = 3;
    localparam int RD_LATENCY      = 1;

    typedef logic [1:0] level_t;

    // Advance a prefetch-buffer index, wrapping after the last entry.
    function automatic level_t wrap_inc(input level_t idx);
        return (idx == level_t'(PF_DEPTH - 1)) ? '0 : idx + 2'd1;
    endfunction

endpackage

// File: rtl/fwft_prefetch_buf.sv
// Three-entry circular register buffer with push/pop and occupancy count.
// The head entry is driven straight from registers so it stays stable while
// the consumer stalls.
module fwft_prefetch_buf
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = FIFO_DATA_WIDTH
) (
    input  logic                  rclk,
    input  logic                  rrst_n,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] head_data,
    output level_t                level
);

    logic [DATA_WIDTH-1:0] mem [PF_DEPTH];
    level_t                head;
    level_t                tail;
    level_t                count;

    // Storage: write the landing word at the tail slot.
    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            for (int k = 0; k < PF_DEPTH; k++) begin
                mem[k] <= '0;
            end
        end else if (push) begin
            mem[tail] <= push_data;
        end
    end

    // Head/tail indices advance independently on pop/push.
    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            head <= '0;
            tail <= '0;
        end else begin
            if (pop) begin
                head <= wrap_inc(head);
            end
            if (push) begin
                tail <= wrap_inc(tail);
            end
        end
    end

    // Occupancy: a simultaneous push and pop leaves the count unchanged.
    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            count <= '0;
        end else begin
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    assign head_data = mem[head];
    assign level     = count;

endmodule

// File: rtl/fifo_fwft_rd_stage.sv
// Read-side output stage of the async FIFO. Issues reads to the read-pointer
// logic, catches the synchronous-RAM data one rclk later and presents it as a
// first-word-fall-through valid/ready stream. rinc looks only at registered
// state and rempty, so there is no combinational path from m_ready to rinc.
module fifo_fwft_rd_stage
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = FIFO_DATA_WIDTH
) (
    input  logic                  rclk,
    input  logic                  rrst_n,
    input  logic                  rempty,
    output logic                  rinc,
    input  logic [DATA_WIDTH-1:0] rdata,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output level_t                buf_level
);

    level_t                level;
    logic [RD_LATENCY-1:0] inflight_p1;
    logic [2:0]            occupancy;
    logic                  push;
    logic                  pop;

    // Words held plus words already requested; a read is issued only while
    // that total leaves room, so the buffer can never overflow. Gating with
    // rrst_n drops rinc the instant reset is asserted.
    assign occupancy = {1'b0, level} + 3'($countones(inflight_p1));
    assign rinc      = rrst_n && !rempty && (occupancy < 3'(PF_DEPTH));

    // ---- stage p0 -> p1: read issued, memory data lands next cycle ----
    // Track reads in flight through the RAM latency.
    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            inflight_p1 <= '0;
        end else begin
            inflight_p1 <= RD_LATENCY'({inflight_p1, rinc});
        end
    end

    // ---- stage p1 -> buffer: capture rdata, head drives the stream ----
    assign push = inflight_p1[RD_LATENCY-1];
    assign pop  = m_valid && m_ready;

    fwft_prefetch_buf #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_buf (
        .rclk      (rclk),
        .rrst_n    (rrst_n),
        .push      (push),
        .push_data (rdata),
        .pop       (pop),
        .head_data (m_data),
        .level     (level)
    );

    assign m_valid   = (level != '0);
    assign buf_level = level;

endmodule

// File: tb/tb_fifo_fwft_rd_stage.sv
// Bench for fifo_fwft_rd_stage: a queue-backed FIFO/RAM model feeds the DUT,
// words are recorded in a scoreboard when loaded and checked in order as the
// stream hands them off.
module tb_fifo_fwft_rd_stage;

    localparam int DW = 8;

    logic          rclk    = 1'b0;
    logic          rrst_n  = 1'b0;
    logic          rempty  = 1'b1;
    logic          rinc;
    logic [DW-1:0] rdata   = '0;
    logic          m_valid;
    logic          m_ready = 1'b0;
    logic [DW-1:0] m_data;
    logic [1:0]    buf_level;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int n_pops   = 0;
    int n_rinc   = 0;

    logic [DW-1:0] fifo_q [$];
    logic [DW-1:0] exp_q  [$];

    logic          infl      = 1'b0;
    logic          hold_prev = 1'b0;
    logic [DW-1:0] data_prev = '0;

    always #5 rclk = ~rclk;

    fifo_fwft_rd_stage #(
        .DATA_WIDTH (DW)
    ) dut (
        .rclk      (rclk),
        .rrst_n    (rrst_n),
        .rempty    (rempty),
        .rinc      (rinc),
        .rdata     (rdata),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_data    (m_data),
        .buf_level (buf_level)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic drive_step();
        @(posedge rclk);
        #1;
    endtask

    task automatic obs_step();
        @(negedge rclk);
        #1;
    endtask

    task automatic load(input logic [DW-1:0] w);
        fifo_q.push_back(w);
        exp_q.push_back(w);
    endtask

    task automatic drain(input string tag, input int budget);
        for (int k = 0; k < budget && exp_q.size() > 0; k++) begin
            obs_step();
        end
        chk(tag, 32'(exp_q.size()), 32'd0);
    endtask

    // FIFO + synchronous RAM model: pop on rinc, data valid next cycle,
    // registered empty flag.
    always @(posedge rclk) begin
        cyc <= cyc + 1;
        if (rinc && fifo_q.size() > 0) begin
            rdata <= fifo_q.pop_front();
        end
        rempty <= (fifo_q.size() == 0);
    end

    // Reference copy of the in-flight flag.
    always @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) infl <= 1'b0;
        else         infl <= rinc;
    end

    // Per-cycle monitor: invariants, hold stability and scoreboard compare.
    always @(negedge rclk) begin
        if (rrst_n) begin
            chk("rinc_while_empty", 32'(rinc && rempty), 32'd0);
            chk("occupancy_le_3", 32'((32'(buf_level) + 32'(infl)) <= 32'd3), 32'd1);
            if (hold_prev) begin
                chk("hold_valid", 32'(m_valid), 32'd1);
                chk("hold_data", 32'(m_data), 32'(data_prev));
            end
            if (rinc) n_rinc++;
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) chk("unexpected_word", 32'(m_data), 32'hFFFF_FFFF);
                else                   chk("data_order", 32'(m_data), 32'(exp_q.pop_front()));
                n_pops++;
            end
            hold_prev = m_valid && !m_ready;
            data_prev = m_data;
        end else begin
            hold_prev = 1'b0;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout, expected test completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int t_fall;
        int t_valid;
        int p0;
        int r0;
        logic reached;

        // 1: reset state with a non-empty FIFO, rinc on release
        load(8'h5A);
        repeat (3) drive_step();
        chk("rst_rinc", 32'(rinc), 32'd0);
        chk("rst_m_valid", 32'(m_valid), 32'd0);
        chk("rst_buf_level", 32'(buf_level), 32'd0);
        chk("rst_m_data", 32'(m_data), 32'd0);
        rrst_n = 1'b1;
        #1;
        chk("rinc_after_release", 32'(rinc), 32'd1);
        m_ready = 1'b1;
        drain("t1_drain", 20);
        repeat (3) drive_step();
        chk("t1_idle_level", 32'(buf_level), 32'd0);

        // 2: three words streamed back to back, first-word latency
        load(8'h11); load(8'h22); load(8'h33);
        t_fall  = -1;
        t_valid = -1;
        for (int k = 0; k < 20; k++) begin
            obs_step();
            if (t_fall < 0 && !rempty) t_fall = cyc;
            if (m_valid) begin
                t_valid = cyc;
                break;
            end
        end
        chk("t2_first_latency", 32'(t_valid - t_fall), 32'd2);
        p0 = n_pops;
        repeat (2) obs_step();
        chk("t2_back_to_back", 32'(n_pops - p0), 32'd2);
        chk("t2_sb_empty", 32'(exp_q.size()), 32'd0);
        obs_step();
        chk("t2_valid_low", 32'(m_valid), 32'd0);

        // 3: backpressure fills the buffer, restart without gaps
        drive_step();
        m_ready = 1'b0;
        r0 = n_rinc;
        for (int k = 0; k < 5; k++) load(8'h31 + 8'(k));
        repeat (10) obs_step();
        chk("t3_rinc_pulses", 32'(n_rinc - r0), 32'd3);
        chk("t3_buf_full", 32'(buf_level), 32'd3);
        chk("t3_head_word", 32'(m_data), 32'h31);
        drive_step();
        m_ready = 1'b1;
        p0 = n_pops;
        repeat (5) obs_step();
        chk("t3_no_gaps", 32'(n_pops - p0), 32'd5);
        chk("t3_sb_empty", 32'(exp_q.size()), 32'd0);

        // 4: toggling ready with eight words queued
        drive_step();
        for (int k = 0; k < 8; k++) load(8'h41 + 8'(k));
        for (int k = 0; k < 60 && exp_q.size() > 0; k++) begin
            m_ready = ~k[0];
            drive_step();
        end
        chk("t4_sb_empty", 32'(exp_q.size()), 32'd0);
        m_ready = 1'b1;
        repeat (3) drive_step();

        // 5: single word
        p0 = n_pops;
        load(8'hA5);
        repeat (8) obs_step();
        chk("t5_one_handshake", 32'(n_pops - p0), 32'd1);
        chk("t5_valid_low", 32'(m_valid), 32'd0);
        chk("t5_rinc_low", 32'(rinc), 32'd0);
        chk("t5_level_zero", 32'(buf_level), 32'd0);

        // 6: asynchronous reset with two words held and one in flight
        drive_step();
        m_ready = 1'b0;
        for (int k = 0; k < 4; k++) load(8'h61 + 8'(k));
        reached = 1'b0;
        for (int k = 0; k < 20; k++) begin
            obs_step();
            if (buf_level == 2'd2 && infl) begin
                reached = 1'b1;
                break;
            end
        end
        chk("t6_setup", 32'(reached), 32'd1);
        rrst_n = 1'b0;
        #1;
        chk("t6_rinc", 32'(rinc), 32'd0);
        chk("t6_m_valid", 32'(m_valid), 32'd0);
        chk("t6_buf_level", 32'(buf_level), 32'd0);
        chk("t6_m_data", 32'(m_data), 32'd0);
        fifo_q.delete();
        exp_q.delete();
        repeat (2) drive_step();
        rrst_n = 1'b1;
        load(8'h71); load(8'h72);
        m_ready = 1'b1;
        drain("t6_drain", 20);
        repeat (3) drive_step();
        chk("t6_level_zero", 32'(buf_level), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fifo_fwft_rd_stage.md
Name: fifo_fwft_rd_stage

Overview:
Read-side output stage of the asynchronous FIFO, directly downstream of the read-pointer/empty-flag logic and the dual-port memory. It drives rinc from rempty and captures memory read data, which arrives with one rclk of latency from a synchronous-read RAM. It presents the data as a first-word-fall-through valid/ready stream. A 3-entry prefetch buffer sustains one word per rclk with no combinational path from m_ready to rinc.

Parameters:
DATA_WIDTH, 8, width of FIFO word and stream data

Ports:
rclk  input  1  read-domain clock
rrst_n  input  1  read-domain reset
rempty  input  1  registered empty flag from read-pointer logic
rinc  output  1  read increment to read-pointer logic; pops one FIFO word
rdata  input  DATA_WIDTH  memory read data; valid exactly 1 rclk after the rinc cycle
m_valid  output  1  stream data valid
m_ready  input  1  stream consumer ready
m_data  output  DATA_WIDTH  stream data, head of prefetch buffer
buf_level  output  2  number of words held in prefetch buffer (0..3)

Behaviour:
- Reset rrst_n, asynchronous, active-low; clock rclk. All state is in the rclk domain.
- Reset values: rinc=0, m_valid=0, m_data=0, buf_level=0, inflight=0, head/tail pointers=0.
- State: held count h (0..3), inflight flag i (a read issued last cycle whose data lands this cycle), 3-entry circular buffer with head/tail indices that wrap 2->0.
- rinc = !rempty && (h + i) < 3. It is combinational from registered state and rempty only and never depends on m_ready. It is never asserted while rempty=1.
- i <= rinc on every rclk edge.
- Push: when i=1, rdata is written at tail and tail advances, in the same cycle i is set.
- Pop: m_valid && m_ready, i.e. head advances at the clock edge.
- m_valid = (h != 0). m_data = buf[head], which is mux-from-registers and stable while m_valid=1 && m_ready=0.
- h_next = h + push - pop. A simultaneous push and pop leaves h unchanged. Pushing into an empty buffer makes the word visible on the next cycle.
- Latency: FIFO non-empty -> rinc in the same cycle -> rdata captured at the next edge -> m_valid high one cycle later. First word reaches m_valid 2 rclk after rempty falls.
- Throughput: with m_ready held high and FIFO non-empty, one word is transferred per rclk continuously (steady state h=1, i=1).
- Overflow is impossible by construction: h + i <= 3 always. A push while h=3 is an assertion failure in the bench.
- Backpressure: m_ready=0 lets h reach 3, then rinc deasserts and the remaining FIFO words stay in the memory.
- Empty: rempty=1 -> no rinc. The buffer drains normally. m_valid falls after the last pop.
- Ordering: words leave in exact FIFO order. No duplication or loss.
- Reset mid-operation: buffer contents and any in-flight read are discarded. rinc drops immediately. The read pointer is reset by the same rrst_n, so no word is consumed without delivery.
- buf_level = h.

Decomposition:
- fifo_pkg: DATA_WIDTH default, constant PF_DEPTH=3, constant RD_LATENCY=1, and a 2-bit level typedef shared with the read-pointer block.
- One sub-module, fwft_prefetch_buf: the 3-entry circular register buffer with push/pop and count.
- The top level holds the rinc/inflight logic and the stream interface.

Test Plan:
1. Reset with rrst_n=0, rempty=0 -> rinc=0, m_valid=0, buf_level=0. Release reset -> rinc=1 in the first cycle.
2. Load FIFO with 0x11, 0x22, 0x33, hold m_ready=1 -> m_data sequence 0x11, 0x22, 0x33 on consecutive cycles. First m_valid occurs 2 cycles after rempty falls.
3. Load 5 words, hold m_ready=0 -> exactly 3 rinc pulses, buf_level=3, m_data=word0 stable. Raise m_ready -> all 5 delivered in order with no gaps after restart.
4. Toggle m_ready 1,0,1,0 with 8 words queued -> no loss or duplication, rinc never asserted while rempty=1, h+i<=3 at every cycle.
5. Single word 0xA5 -> m_valid high for one handshake, then m_valid=0, rinc=0, buf_level=0.
6. Assert rrst_n=0 while buf_level=2 and i=1 -> all outputs return to reset values asynchronously. After release with a refilled FIFO, the first word out is the new head.
